// File: rtl/k2_ctrl_pkg.sv
// ============================================================================
// k2_ctrl_pkg
// Shared types and default widths for the K2 run-control sequencer.
//   run_state_t   : sequencer states (IDLE, LOAD, RUN, STEP, HALT)
//   K2_ADDR_BITS  : default program address width (matches the core PC)
//   K2_INSTR_BITS : default instruction word width
// ============================================================================
package k2_ctrl_pkg;

    localparam int K2_ADDR_BITS  = 4;
    localparam int K2_INSTR_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STEP,
        HALT
    } run_state_t;

endpackage

// File: rtl/k2_sat_counter.sv
// ============================================================================
// k2_sat_counter
// Up-counter with synchronous clear and increment enable.
// The counter holds at all-ones instead of wrapping.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (count returns to 0)
//   clr_i   : synchronous clear, takes priority over inc_i
//   inc_i   : increment enable
//   count_o : current count
// ============================================================================
module k2_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment; once all-ones is reached the count stays there.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/k2_run_controller.sv
// ============================================================================
// k2_run_controller
// Run-control sequencer for the K2 8-bit processor core. Loads the program
// memory over a valid/ready stream, holds the core in reset until started,
// gates core execution (run / stop / single-step / breakpoint) through a
// clock enable and counts executed cycles.
//
// Optional feature macro: K2_WATCHDOG_EN
//   Defined   : a consecutive-RUN watchdog halts the core after WDT_CYCLES
//               cycles and raises the sticky wdt_timeout flag.
//   Undefined : no watchdog logic, wdt_timeout tied low.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_start            : request program load (IDLE only)
//   load_valid/load_ready : load stream handshake (ready while in LOAD)
//   load_data, load_last  : load word and end-of-load marker
//   imem_we/addr/wdata    : registered instruction memory write port
//   start, stop, step     : run / halt / single-step commands
//   abort                 : return to IDLE and reset the core (top priority)
//   bp_en, bp_addr        : program-address breakpoint
//   pc                    : core program address
//   proc_en               : core clock enable
//   proc_rst_n            : registered active-low core reset
//   halted, bp_hit        : HALT state flag, breakpoint halt pulse
//   cycle_count           : saturating count of proc_en cycles
//   wdt_timeout           : sticky watchdog flag
// ============================================================================
module k2_run_controller
    import k2_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = K2_ADDR_BITS,
    parameter int INSTR_BITS = K2_INSTR_BITS,
    parameter int CNT_BITS   = 16,
    parameter int WDT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [INSTR_BITS-1:0] load_data,
    input  logic                  load_last,
    output logic                  imem_we,
    output logic [ADDR_BITS-1:0]  imem_addr,
    output logic [INSTR_BITS-1:0] imem_wdata,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  abort,
    input  logic                  bp_en,
    input  logic [ADDR_BITS-1:0]  bp_addr,
    input  logic [ADDR_BITS-1:0]  pc,
    output logic                  proc_en,
    output logic                  proc_rst_n,
    output logic                  halted,
    output logic                  bp_hit,
    output logic [CNT_BITS-1:0]   cycle_count,
    output logic                  wdt_timeout
);

    run_state_t            state_q, state_d;
    logic [ADDR_BITS-1:0]  loadIndex_q, loadIndex_d;
    logic                  imemWe_q;
    logic [ADDR_BITS-1:0]  imemAddr_q;
    logic [INSTR_BITS-1:0] imemWdata_q;
    logic                  procRstN_q;
    logic                  bpHit_q;
    logic                  bpArmed_q;

    logic bpMatch;
    logic loadFire;
    logic bpHalt;
    logic wdtHalt;
    logic cycleClr;

    // bp_armed is dropped after a breakpoint halt so that resuming or stepping
    // from the breakpoint address does not immediately halt again.
    assign bpMatch  = bp_en & bpArmed_q & (pc == bp_addr);
    assign loadFire = (state_q == LOAD) & load_valid & ~abort;
    assign bpHalt   = (state_q == RUN) & ~abort & ~stop & bpMatch;
    assign cycleClr = (state_q == IDLE) & start & ~load_start & ~abort;

    // Only Mealy output: the core is stopped before it executes the
    // breakpoint instruction.
    assign proc_en = ((state_q == RUN) & ~bpMatch) | (state_q == STEP);

    assign load_ready = (state_q == LOAD);
    assign halted     = (state_q == HALT);
    assign imem_we    = imemWe_q;
    assign imem_addr  = imemAddr_q;
    assign imem_wdata = imemWdata_q;
    assign proc_rst_n = procRstN_q;
    assign bp_hit     = bpHit_q;

    // Next-state decode; abort overrides every state.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d = LOAD;
                    end else if (start) begin
                        state_d = RUN;
                    end
                end
                LOAD: begin
                    if (load_valid && load_last) begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (stop || bpMatch || wdtHalt) begin
                        state_d = HALT;
                    end
                end
                STEP: begin
                    state_d = HALT;
                end
                HALT: begin
                    if (step) begin
                        state_d = STEP;
                    end else if (start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Load word index restarts on every accepted load request and advances
    // with each handshake, wrapping naturally at the address width.
    always_comb begin
        loadIndex_d = loadIndex_q;
        if ((state_q == IDLE) && load_start && !abort) begin
            loadIndex_d = '0;
        end else if (loadFire) begin
            loadIndex_d = loadIndex_q + ADDR_BITS'(1);
        end
    end

    // State, load path and control registers. The core is released from
    // reset exactly when the sequencer is in an execution state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            loadIndex_q <= '0;
            imemWe_q    <= 1'b0;
            imemAddr_q  <= '0;
            imemWdata_q <= '0;
            procRstN_q  <= 1'b0;
            bpHit_q     <= 1'b0;
            bpArmed_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            loadIndex_q <= loadIndex_d;
            imemWe_q    <= loadFire;
            if (loadFire) begin
                imemAddr_q  <= loadIndex_q;
                imemWdata_q <= load_data;
            end
            procRstN_q <= (state_d == RUN) || (state_d == STEP) || (state_d == HALT);
            bpHit_q    <= bpHalt;
            if (abort) begin
                bpArmed_q <= 1'b1;
            end else if (bpHalt) begin
                bpArmed_q <= 1'b0;
            end else if (proc_en) begin
                bpArmed_q <= 1'b1;
            end
        end
    end

    // Executed-cycle counter, cleared when a fresh run starts from IDLE.
    k2_sat_counter #(
        .WIDTH(CNT_BITS)
    ) u_cycle_counter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (cycleClr),
        .inc_i  (proc_en),
        .count_o(cycle_count)
    );

`ifdef K2_WATCHDOG_EN
    localparam int WDT_BITS = $clog2(WDT_CYCLES + 1);

    logic [WDT_BITS-1:0] wdtCount;
    logic                wdtTimeout_q;

    // The watchdog count is held at zero outside RUN, so every entry into RUN
    // starts from a clean count. It fires on the last allowed RUN cycle,
    // unless stop or a breakpoint is already halting the core.
    k2_sat_counter #(
        .WIDTH(WDT_BITS)
    ) u_wdt_counter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (state_q != RUN),
        .inc_i  (state_q == RUN),
        .count_o(wdtCount)
    );

    assign wdtHalt = (state_q == RUN) & ~abort & ~stop & ~bpMatch
                   & (wdtCount == WDT_BITS'(WDT_CYCLES - 1));

    // Sticky timeout flag, cleared by abort or by the next start command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdtTimeout_q <= 1'b0;
        end else if (abort) begin
            wdtTimeout_q <= 1'b0;
        end else if (wdtHalt) begin
            wdtTimeout_q <= 1'b1;
        end else if (start) begin
            wdtTimeout_q <= 1'b0;
        end
    end

    assign wdt_timeout = wdtTimeout_q;
`else
    assign wdtHalt     = 1'b0;
    assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_k2_run_controller.sv
// ============================================================================
// tb_k2_run_controller
// Self-checking bench for k2_run_controller. Instruction memory writes are
// checked against a queue of expected {addr, data} pairs filled as load words
// are driven. A tiny core stub advances pc on every proc_en cycle.
// ============================================================================
module tb_k2_run_controller;

    localparam int AB = 4;
    localparam int IB = 8;
    localparam int CB = 4;

    localparam logic [4:0] C_LOAD  = 5'b10000;
    localparam logic [4:0] C_START = 5'b01000;
    localparam logic [4:0] C_STOP  = 5'b00100;
    localparam logic [4:0] C_STEP  = 5'b00010;
    localparam logic [4:0] C_ABORT = 5'b00001;

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [IB-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start, load_valid, load_last;
    logic          start, stop, step, abort, bp_en;
    logic [IB-1:0] load_data;
    logic [AB-1:0] bp_addr;
    logic [AB-1:0] pcReg = '0;
    logic          load_ready, imem_we, proc_en, proc_rst_n, halted, bp_hit, wdt_timeout;
    logic [AB-1:0] imem_addr;
    logic [IB-1:0] imem_wdata;
    logic [CB-1:0] cycle_count;

    wr_t           expQ[$];
    wr_t           gotWr;
    logic [AB-1:0] tbIndex = '0;
    int            checkCount = 0;
    int            errorCount = 0;
    int            writeCount = 0;
    int            bpHitCount = 0;
    int            expHits = 0;
    int            runCycles;

    always #5 clk = ~clk;

    k2_run_controller #(
        .ADDR_BITS (AB),
        .INSTR_BITS(IB),
        .CNT_BITS  (CB),
        .WDT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .abort      (abort),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pcReg),
        .proc_en    (proc_en),
        .proc_rst_n (proc_rst_n),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .cycle_count(cycle_count),
        .wdt_timeout(wdt_timeout)
    );

    // Core stub: program counter held at 0 in reset, advancing on proc_en.
    always @(posedge clk) begin
        if (!proc_rst_n) begin
            pcReg <= '0;
        end else if (proc_en) begin
            pcReg <= pcReg + 1'b1;
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Memory write monitor: every imem_we pulse must match the oldest
    // expected write; breakpoint pulses are tallied as they appear.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checkOutput("imem_we_unexpected", 32'(imem_we), 32'd0);
            end else begin
                gotWr = expQ.pop_front();
                checkOutput("imem_addr", 32'(imem_addr), 32'(gotWr.addr));
                checkOutput("imem_wdata", 32'(imem_wdata), 32'(gotWr.data));
            end
        end
        if (bp_hit) begin
            bpHitCount++;
        end
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Pulse a command vector {load_start,start,stop,step,abort} for one clock.
    task automatic applyStimulus(input logic [4:0] ctl);
        {load_start, start, stop, step, abort} = ctl;
        stepClk();
        {load_start, start, stop, step, abort} = '0;
    endtask

    // Present one load word for one clock and record the write it must cause.
    task automatic loadWord(input logic [IB-1:0] data, input logic last);
        wr_t w;
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        w.addr     = tbIndex;
        w.data     = data;
        expQ.push_back(w);
        tbIndex    = tbIndex + 1'b1;
        stepClk();
    endtask

    // Restart from IDLE and run from pc=0 into the breakpoint at address 4.
    task automatic runToBreakpoint();
        applyStimulus(C_ABORT);
        stepClk();
        checkOutput("abort_core_rst", 32'(proc_rst_n), 32'd0);
        checkOutput("abort_not_halted", 32'(halted), 32'd0);
        applyStimulus(C_START);
        repeat (4) stepClk();
        checkOutput("bp_proc_en_low", 32'(proc_en), 32'd0);
        checkOutput("bp_still_run", 32'(halted), 32'd0);
        stepClk();
        checkOutput("bp_halted", 32'(halted), 32'd1);
        checkOutput("bp_hit_set", 32'(bp_hit), 32'd1);
        checkOutput("bp_cycle_count", 32'(cycle_count), 32'd4);
        expHits++;
        stepClk();
        checkOutput("bp_hit_pulse_end", 32'(bp_hit), 32'd0);
        checkOutput("bp_hit_total", 32'(bpHitCount), 32'(expHits));
    endtask

    initial begin
        {load_start, start, stop, step, abort} = '0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        bp_en      = 1'b0;
        bp_addr    = '0;

        // Reset values.
        #22;
        checkOutput("rst_core_rst", 32'(proc_rst_n), 32'd0);
        checkOutput("rst_proc_en", 32'(proc_en), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
        checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("rst_bp_hit", 32'(bp_hit), 32'd0);
        checkOutput("rst_cycle_count", 32'(cycle_count), 32'd0);
        checkOutput("rst_wdt", 32'(wdt_timeout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stepClk();

        // Three-word program load.
        applyStimulus(C_LOAD);
        tbIndex = '0;
        checkOutput("load_ready", 32'(load_ready), 32'd1);
        loadWord(8'h3A, 1'b0);
        loadWord(8'hC5, 1'b0);
        loadWord(8'h7E, 1'b1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (2) stepClk();
        checkOutput("load3_writes", 32'(writeCount), 32'd3);
        checkOutput("load3_idle_ready", 32'(load_ready), 32'd0);
        checkOutput("load3_core_rst", 32'(proc_rst_n), 32'd0);

        // Run five cycles then stop.
        applyStimulus(C_START);
        checkOutput("start_core_rel", 32'(proc_rst_n), 32'd1);
        checkOutput("start_proc_en", 32'(proc_en), 32'd1);
        repeat (4) stepClk();
        applyStimulus(C_STOP);
        checkOutput("stop_cycle_count", 32'(cycle_count), 32'd5);
        checkOutput("stop_halted", 32'(halted), 32'd1);
        checkOutput("stop_proc_en", 32'(proc_en), 32'd0);

        // load_start outside IDLE is ignored.
        applyStimulus(C_LOAD);
        checkOutput("halt_load_ignored", 32'(load_ready), 32'd0);
        checkOutput("halt_load_halted", 32'(halted), 32'd1);

        // Breakpoint, then single step off it.
        bp_en   = 1'b1;
        bp_addr = 4'd4;
        runToBreakpoint();
        applyStimulus(C_STEP);
        checkOutput("step_proc_en", 32'(proc_en), 32'd1);
        checkOutput("step_not_halted", 32'(halted), 32'd0);
        stepClk();
        checkOutput("step_back_halt", 32'(halted), 32'd1);
        checkOutput("step_proc_en_off", 32'(proc_en), 32'd0);
        checkOutput("step_cycle_count", 32'(cycle_count), 32'd5);
        checkOutput("step_no_bp_hit", 32'(bpHitCount), 32'(expHits));

        // start and step together in HALT take the step.
        runToBreakpoint();
        applyStimulus(C_START | C_STEP);
        checkOutput("both_proc_en", 32'(proc_en), 32'd1);
        stepClk();
        checkOutput("both_step_taken", 32'(halted), 32'd1);
        checkOutput("both_cycle_count", 32'(cycle_count), 32'd5);

        // Resuming at the breakpoint address must execute it, not re-hit.
        runToBreakpoint();
        applyStimulus(C_START);
        checkOutput("resume_proc_en", 32'(proc_en), 32'd1);
        checkOutput("resume_running", 32'(halted), 32'd0);
        applyStimulus(C_STOP);
        checkOutput("resume_cycle_count", 32'(cycle_count), 32'd5);
        checkOutput("resume_no_bp_hit", 32'(bpHitCount), 32'(expHits));

        // Cycle counter clears on a fresh start and saturates at all-ones.
        bp_en = 1'b0;
        applyStimulus(C_ABORT);
        stepClk();
        applyStimulus(C_START);
        checkOutput("sat_cleared", 32'(cycle_count), 32'd0);
        for (int i = 0; i < 24; i++) begin
            if (halted) begin
                applyStimulus(C_START);
            end else begin
                stepClk();
            end
        end
        checkOutput("sat_cycle_count", 32'(cycle_count), 32'd15);
        applyStimulus(C_STOP);
        checkOutput("sat_halted", 32'(halted), 32'd1);

        // Abort during a load: the in-flight word is dropped.
        applyStimulus(C_ABORT);
        stepClk();
        applyStimulus(C_LOAD);
        tbIndex = '0;
        loadWord(8'hA5, 1'b0);
        load_data = 8'h3C;
        abort     = 1'b1;
        stepClk();
        abort      = 1'b0;
        load_valid = 1'b0;
        checkOutput("abort_load_ready", 32'(load_ready), 32'd0);
        repeat (3) stepClk();
        checkOutput("abort_load_writes", 32'(writeCount), 32'd4);

        // Seventeen back-to-back words: index restarts at 0 and wraps 15->0.
        applyStimulus(C_LOAD);
        tbIndex = '0;
        for (int i = 0; i < 17; i++) begin
            loadWord(IB'($urandom_range(0, 255)), (i == 16));
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (2) stepClk();
        checkOutput("wrap_writes", 32'(writeCount), 32'd21);
        checkOutput("wrap_idle", 32'(load_ready), 32'd0);

`ifdef K2_WATCHDOG_EN
        // Watchdog halts after eight consecutive RUN cycles.
        applyStimulus(C_ABORT);
        stepClk();
        applyStimulus(C_START);
        runCycles = 0;
        while (!halted && runCycles < 20) begin
            stepClk();
            runCycles++;
        end
        checkOutput("wdt_run_cycles", 32'(runCycles), 32'd8);
        checkOutput("wdt_flag_set", 32'(wdt_timeout), 32'd1);
        checkOutput("wdt_cycle_count", 32'(cycle_count), 32'd8);
        applyStimulus(C_START);
        checkOutput("wdt_flag_cleared", 32'(wdt_timeout), 32'd0);
        checkOutput("wdt_resumed", 32'(halted), 32'd0);
        applyStimulus(C_STOP);
`else
        checkOutput("wdt_tied_low", 32'(wdt_timeout), 32'd0);
`endif

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
